// File: rtl/mem_load_unit.sv
// Load sequencer: issues one word-aligned data-memory read, waits MEM_LAT cycles,
// then captures the word shifted so the addressed byte/halfword sits at bit 0.
module mem_load_unit #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mdr_out,
  output logic [1:0]  size_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MEM_LAT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_off;
  logic [1:0]       r_size;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_mem_rd;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mdr;
  logic [1:0]       r_size_out;
  logic             w_legal;

  // NOTE: w_legal gets a default before the case so no path leaves it unassigned
  // (an unassigned path in always_comb would infer a latch).
  always_comb begin
    w_legal = 1'b0;
    case (size)
      2'b00:   w_legal = 1'b1;
      2'b01:   w_legal = ~addr[0];
      2'b10:   w_legal = (addr[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_off      <= 2'b00;
      r_size     <= 2'b00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_mdr      <= '0;
      r_size_out <= 2'b10;
    end else begin
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_mem_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_off      <= addr[1:0];
            r_size     <= size;
            r_mem_addr <= {addr[31:2], 2'b00};
            r_busy     <= 1'b1;
            if (w_legal) begin
              r_state  <= S_READ;
              r_mem_rd <= 1'b1;
            end else begin
              r_state <= S_FAULT;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        S_READ: begin
          r_state <= S_WAIT;
          r_cnt   <= '0;
        end
        S_WAIT: begin
          // Capture happens on the edge leaving the last wait cycle, which is
          // when mem_rdata is valid, so done follows in the very next cycle.
          if (r_cnt == LP_LAST) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_mdr      <= mem_rdata >> {r_off, 3'b000};
            r_size_out <= r_size;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE, S_FAULT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign mem_addr = r_mem_addr;
  assign mem_rd   = r_mem_rd;
  assign mdr_out  = r_mdr;
  assign size_out = r_size_out;

endmodule
